// File: rtl/fifo72togmii.sv
// fifo72togmii: pops 72-bit {ctl,data} words from a non-FWFT FIFO and serialises them onto GMII TX,
// enforcing an inter-frame gap and flagging mid-frame underruns with gmii_tx_er.
module fifo72togmii #(
    parameter logic [3:0] Ifg = 4'd12
) (
    input  logic        gmii_tx_clk,
    input  logic        sys_rst_n,
    input  logic [71:0] dout,
    input  logic        empty,
    output logic        rd_en,
    output logic        rd_clk,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_er,
    output logic        underrun
);
    typedef enum logic [2:0] {IDLE, SEND, ABORT, DROP, IFG} state_t;
    state_t      state;
    logic [71:0] nxt, cur;
    logic        nxt_valid, rd_pending;
    logic [2:0]  lane, last;
    logic [3:0]  ifg_cnt;
    logic        nxt_gap, nxt_tail, cur_tail;

    assign rd_clk   = gmii_tx_clk;
    assign rd_en    = sys_rst_n & !empty & !nxt_valid & !rd_pending;
    assign nxt_gap  = nxt[71:64] == 8'h00;
    assign nxt_tail = !nxt_gap && nxt[71:64] != 8'hFF;
    assign cur_tail = cur[71:64] != 8'hFF;

    // last lane sent is the one just below the lowest clear ctl bit
    always_comb begin
        last = 3'd7;
        for (int i = 7; i >= 1; i--)
            if (!cur[64+i]) last = 3'(i - 1);
    end

    always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            nxt        <= '0;
            cur        <= '0;
            nxt_valid  <= 1'b0;
            rd_pending <= 1'b0;
            lane       <= '0;
            ifg_cnt    <= '0;
            gmii_tx_en <= 1'b0;
            gmii_txd   <= '0;
            gmii_tx_er <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            rd_pending <= rd_en;
            gmii_tx_er <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                IDLE: if (nxt_valid) begin
                    nxt_valid <= 1'b0;
                    if (!nxt_gap) begin
                        cur        <= nxt;
                        lane       <= '0;
                        gmii_txd   <= nxt[7:0];
                        gmii_tx_en <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: if (lane != last) begin
                    lane     <= lane + 3'd1;
                    gmii_txd <= cur[{lane + 3'd1, 3'b000} +: 8];
                end else if (cur_tail || nxt_valid && nxt_gap) begin
                    nxt_valid  <= cur_tail ? nxt_valid : 1'b0;
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= '0;
                    ifg_cnt    <= Ifg - 4'd1;
                    state      <= IFG;
                end else if (nxt_valid) begin
                    nxt_valid <= 1'b0;
                    cur       <= nxt;
                    lane      <= '0;
                    gmii_txd  <= nxt[7:0];
                end else begin
                    gmii_txd   <= '0;
                    gmii_tx_er <= 1'b1;
                    underrun   <= 1'b1;
                    state      <= ABORT;
                end
                ABORT: begin
                    gmii_tx_en <= 1'b0;
                    state      <= DROP;
                end
                DROP: if (nxt_valid) begin
                    nxt_valid <= 1'b0;
                    if (nxt_gap || nxt_tail) begin
                        ifg_cnt <= Ifg - 4'd1;
                        state   <= IFG;
                    end
                end
                IFG: begin
                    ifg_cnt <= ifg_cnt - 4'd1;
                    state   <= ifg_cnt == 4'd0 ? IDLE : IFG;
                end
                default: state <= IDLE;
            endcase
            // capture has priority; a pending read implies nxt was empty, so it never collides with a consume
            if (rd_pending) begin
                nxt       <= dout;
                nxt_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo72togmii.sv
// tb_fifo72togmii: scoreboard bench; a FIFO model feeds the DUT, a frame-level model predicts the line bytes.
module tb_fifo72togmii;
    logic        gmii_tx_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [71:0] dout = '0;
    logic        empty = 1'b1;
    logic        rd_en, rd_clk, gmii_tx_en, gmii_tx_er, underrun;
    logic [7:0]  gmii_txd;

    int checks = 0, errors = 0;
    logic [71:0] fifo_q[$];
    int          rd_ptr = 0;
    logic [8:0]  exp_q[$];
    int cyc = 0, run_lo = 0, last_gap = -1, tx_cycles = 0, uflow = 0, rd_count = 0, seen_hi = 0;
    int lat_req = 0, lat_done = 0, t_start = -1;

    fifo72togmii #(.Ifg(4'd12)) dut (
        .gmii_tx_clk(gmii_tx_clk), .sys_rst_n(sys_rst_n), .dout(dout), .empty(empty),
        .rd_en(rd_en), .rd_clk(rd_clk), .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd),
        .gmii_tx_er(gmii_tx_er), .underrun(underrun)
    );

    always #5 gmii_tx_clk = ~gmii_tx_clk;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    // non-FWFT FIFO: data appears on dout the cycle after rd_en
    always @(posedge gmii_tx_clk or negedge sys_rst_n)
        if (!sys_rst_n) rd_ptr <= 0;
        else if (rd_en) begin
            dout   <= fifo_q[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end

    always @(posedge gmii_tx_clk) begin
        #2;
        empty = rd_ptr >= fifo_q.size();
    end

    always @(negedge gmii_tx_clk) begin
        cyc++;
        if (sys_rst_n) begin
            if (rd_en) begin
                rd_count++;
                chk("rd_en_while_empty", int'(empty), 0);
            end
            if (underrun) uflow++;
            if (lat_req != lat_done && t_start < 0 && !empty) begin
                t_start = cyc;
                chk("rd_en_in_T", int'(rd_en), 1);
            end
            if (gmii_tx_en) begin
                tx_cycles++;
                if (lat_req != lat_done && t_start >= 0) begin
                    chk("first_byte_latency", cyc - t_start, 3);
                    lat_done++;
                    t_start = -1;
                end
                if (seen_hi != 0 && run_lo > 0) last_gap = run_lo;
                run_lo = 0;
                seen_hi = 1;
                if (exp_q.size() == 0) chk("unexpected_byte", {gmii_tx_er, gmii_txd}, 'h1ff);
                else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("line_byte", {gmii_tx_er, gmii_txd}, e);
                    chk("underrun_pulse", int'(underrun), int'(e[8]));
                end
            end else begin
                run_lo++;
                if (gmii_tx_er || underrun) chk("er_without_en", {gmii_tx_er, underrun}, 0);
            end
        end
    end

    // frame-level model: a word contributes its lanes below the lowest clear ctl bit
    task automatic expect_word(input logic [71:0] w);
        int n;
        n = 0;
        while (n < 8 && w[64+n]) n++;
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, w[8*i +: 8]});
    endtask

    task automatic push_words(input logic [71:0] ws[$], input bit model);
        @(posedge gmii_tx_clk); #1;
        foreach (ws[i]) begin
            fifo_q.push_back(ws[i]);
            if (model) expect_word(ws[i]);
        end
    endtask

    function automatic logic [71:0] mk(input logic [7:0] ctl, input logic [7:0] base);
        logic [71:0] w;
        w[71:64] = ctl;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = base + 8'(i);
        return w;
    endfunction

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || rd_ptr < fifo_q.size() || gmii_tx_en) && k < budget) begin
            @(negedge gmii_tx_clk);
            k++;
        end
        chk({name, "_timeout"}, int'(k >= budget), 0);
        repeat (20) @(negedge gmii_tx_clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [71:0] ws[$];
        int base_tx, base_rd, base_uf, k;
        logic [7:0] c;
        repeat (3) @(posedge gmii_tx_clk);
        #1;
        chk("rst_tx_en", int'(gmii_tx_en), 0);
        chk("rst_txd", int'(gmii_txd), 0);
        chk("rst_tx_er", int'(gmii_tx_er), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_underrun", int'(underrun), 0);
        sys_rst_n = 1'b1;
        repeat (5) @(posedge gmii_tx_clk);

        // 64-byte frame plus two gap words
        base_tx = tx_cycles;
        ws = {};
        for (int i = 0; i < 8; i++) ws.push_back(mk(8'hFF, 8'(8 * i)));
        ws.push_back(72'h0); ws.push_back(72'h0);
        push_words(ws, 1);
        drain("frame64", 400);
        chk("frame64_len", tx_cycles - base_tx, 64);
        chk("frame64_drained", rd_ptr, fifo_q.size());

        // 61-byte frame ending in a 5-lane tail
        base_tx = tx_cycles;
        ws = {};
        for (int i = 0; i < 7; i++) ws.push_back(mk(8'hFF, 8'(8 * i)));
        ws.push_back(mk(8'h1F, 8'd56));
        push_words(ws, 1);
        drain("frame61", 400);
        chk("frame61_len", tx_cycles - base_tx, 61);

        // back-to-back frames: 3-lane tail then a 16-byte frame
        ws = {};
        ws.push_back(mk(8'hFF, 8'h80)); ws.push_back(mk(8'h07, 8'h88));
        ws.push_back(mk(8'hFF, 8'h90)); ws.push_back(mk(8'hFF, 8'h98)); ws.push_back(72'h0);
        lat_req++;
        push_words(ws, 1);
        drain("b2b", 400);
        chk("b2b_gap", last_gap, 13);
        chk("b2b_latency_seen", lat_done, lat_req);

        // mid-frame underrun, dropped tail, then a fresh frame
        base_uf = uflow;
        ws = {};
        ws.push_back(mk(8'hFF, 8'hA0)); ws.push_back(mk(8'hFF, 8'hA8));
        push_words(ws, 1);
        exp_q.push_back(9'h100);
        repeat (20) @(posedge gmii_tx_clk);
        ws = {};
        ws.push_back(mk(8'h03, 8'hB0));
        push_words(ws, 0);
        ws = {};
        ws.push_back(mk(8'hFF, 8'hC0)); ws.push_back(72'h0);
        push_words(ws, 1);
        drain("underrun", 400);
        chk("underrun_count", uflow - base_uf, 1);

        // gap words only
        base_tx = tx_cycles;
        base_rd = rd_count;
        ws = {};
        for (int i = 0; i < 5; i++) ws.push_back(72'h0);
        push_words(ws, 1);
        drain("gaps", 200);
        chk("gaps_tx_en", tx_cycles - base_tx, 0);
        chk("gaps_reads", rd_count - base_rd, 5);

        // reset during byte 10
        ws = {};
        ws.push_back(mk(8'hFF, 8'h40)); ws.push_back(mk(8'hFF, 8'h48)); ws.push_back(72'h0);
        push_words(ws, 1);
        k = 0;
        while (!(gmii_tx_en && gmii_txd == 8'h4A) && k < 200) begin
            @(negedge gmii_tx_clk);
            k++;
        end
        chk("reach_byte10", int'(k >= 200), 0);
        #1 sys_rst_n = 1'b0;
        #1;
        chk("async_tx_en", int'(gmii_tx_en), 0);
        chk("async_txd", int'(gmii_txd), 0);
        chk("async_tx_er", int'(gmii_tx_er), 0);
        chk("async_rd_en", int'(rd_en), 0);
        chk("async_underrun", int'(underrun), 0);
        exp_q.delete();
        fifo_q.delete();
        repeat (3) @(posedge gmii_tx_clk);
        #1 sys_rst_n = 1'b1;
        repeat (5) @(posedge gmii_tx_clk);
        base_tx = tx_cycles;
        ws = {};
        ws.push_back(mk(8'hFF, 8'hE0)); ws.push_back(72'h0);
        lat_req++;
        push_words(ws, 1);
        drain("post_reset", 200);
        chk("post_reset_len", tx_cycles - base_tx, 8);
        chk("post_reset_latency_seen", lat_done, lat_req);

        // randomized frames, FIFO kept fed
        ws = {};
        for (int f = 0; f < 15; f++) begin
            k = int'($urandom_range(0, 4));
            for (int i = 0; i < k; i++) ws.push_back({8'hFF, $urandom, $urandom});
            if ($urandom_range(0, 1) == 1) begin
                do c = 8'($urandom) | 8'h01; while (c == 8'hFF);
                ws.push_back({c, $urandom, $urandom});
            end else begin
                ws.push_back({8'hFF, $urandom, $urandom});
                ws.push_back(72'h0);
            end
            k = int'($urandom_range(0, 2));
            for (int i = 0; i < k; i++) ws.push_back(72'h0);
        end
        push_words(ws, 1);
        drain("random", 5000);
        chk("final_scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
